// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues in-order
// instruction-memory requests and buffers returned words in a small queue
// that feeds the IF_ID register. The PCLocker and IF_IDLocker holds are
// active-low: 1 means run, 0 means hold. A redirect flushes the queue and
// marks every in-flight fetch for discard.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCLocker,
   input  logic        IF_IDLocker,
   input  logic        redirectValid,
   input  logic [31:0] redirectPC,
   output logic        imemReqValid,
   output logic [31:0] imemReqAddr,
   input  logic        imemReqReady,
   input  logic        imemRespValid,
   input  logic [31:0] imemRespData,
   output logic        instValid,
   output logic [31:0] instData,
   output logic [31:0] instPC
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

   // Program counter and in-flight bookkeeping.
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;

   // Address FIFO: PCs of accepted requests that will still be enqueued.
   logic [31:0]   af_mem [QDEPTH];
   logic [PW-1:0] af_rd_q, af_rd_d;
   logic [PW-1:0] af_wr_q, af_wr_d;

   // Instruction queue.
   logic [31:0]   q_data [QDEPTH];
   logic [31:0]   q_pc   [QDEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          pop;
   logic          req_fire;
   logic          resp_live;
   logic          resp_drop;
   logic          resp_keep;
   logic          push;
   logic [CW:0]   credit_used;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirectPC[1:0];

   assign imemReqAddr = pc_q;
   assign instValid   = (count_q != '0);
   assign instData    = q_data[head_q];
   assign instPC      = q_pc[head_q];

   // Handshake decode: head pop, issue credit and response classification.
   always_comb begin
      pop         = (count_q != '0) & IF_IDLocker & ~redirectValid;
      // Queue slots after this cycle's pop plus in-flight requests must leave room.
      credit_used = {1'b0, count_q} - (CW + 1)'(pop) + {1'b0, out_q};
      imemReqValid = rst_n & PCLocker & ~redirectValid & (credit_used < QDEPTH_W);
      req_fire    = imemReqValid & imemReqReady;
      // A response with nothing outstanding is a stray and is ignored entirely.
      resp_live   = imemRespValid & (out_q != '0);
      resp_drop   = resp_live & (drop_q != '0);
      resp_keep   = resp_live & (drop_q == '0);
      push        = resp_keep & ~redirectValid;
   end

   // Next-state for PC, counters and pointers; a redirect overrides everything.
   always_comb begin
      pc_d    = pc_q;
      out_d   = out_q;
      drop_d  = drop_q;
      af_rd_d = af_rd_q;
      af_wr_d = af_wr_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (redirectValid) begin
         pc_d    = {redirectPC[31:2], 2'b00};
         // Everything still in flight after this cycle's response is old-path.
         out_d   = out_q - CW'(resp_live);
         drop_d  = out_q - CW'(resp_live);
         af_rd_d = '0;
         af_wr_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (req_fire) begin
            pc_d    = pc_q + 32'd4;
            af_wr_d = af_wr_q + 1'b1;
         end
         // Dropped responses never had their address kept in the FIFO.
         if (resp_keep) begin
            af_rd_d = af_rd_q + 1'b1;
         end
         if (resp_drop) begin
            drop_d = drop_q - 1'b1;
         end
         out_d = out_q + CW'(req_fire) - CW'(resp_live);
         if (push) begin
            tail_d = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
         af_rd_q <= '0;
         af_wr_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         af_rd_q <= af_rd_d;
         af_wr_q <= af_wr_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Address FIFO storage: remember the PC of each accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         af_mem <= '{default: '0};
      end else if (req_fire) begin
         af_mem[af_wr_q] <= pc_q;
      end
   end

   // Instruction queue storage: returned word paired with its fetch PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_data <= '{default: '0};
         q_pc   <= '{default: '0};
      end else if (push) begin
         q_data[tail_q] <= imemRespData;
         q_pc[tail_q]   <= af_mem[af_rd_q];
      end
   end

   // Credit invariant: queue plus in-flight never exceeds the depth.
   assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, count_q} + {1'b0, out_q}) <= QDEPTH_W);

   // No push ever lands on a full queue.
   assert property (@(posedge clk) disable iff (!rst_n)
      push |-> ({1'b0, count_q} < QDEPTH_W));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
// and a queue-level reference of which fetched PCs must reach IF_ID.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          QD     = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCLocker = 1'b0;
   logic        IF_IDLocker = 1'b1;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectPC = 32'h0;
   logic        imemReqValid;
   logic [31:0] imemReqAddr;
   logic        imemReqReady = 1'b1;
   logic        imemRespValid = 1'b0;
   logic [31:0] imemRespData = 32'h0;
   logic        instValid;
   logic [31:0] instData;
   logic [31:0] instPC;

   fetch_unit #(
      .RESET_PC (RST_PC),
      .QDEPTH   (QD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCLocker      (PCLocker),
      .IF_IDLocker   (IF_IDLocker),
      .redirectValid (redirectValid),
      .redirectPC    (redirectPC),
      .imemReqValid  (imemReqValid),
      .imemReqAddr   (imemReqAddr),
      .imemReqReady  (imemReqReady),
      .imemRespValid (imemRespValid),
      .imemRespData  (imemRespData),
      .instValid     (instValid),
      .instData      (instData),
      .instPC        (instPC)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_t;

   req_t        inflight[$];   // accepted requests, oldest first
   inst_t       expq[$];       // instructions that must appear at IF_ID, in order
   logic [31:0] m_pc = RST_PC;
   int          cyc = 0;
   int          lat = 1;
   int          checks = 0;
   int          errors = 0;
   bit          stray = 1'b0;
   bit          m_exp_valid, m_pop, m_exp_req, m_resp;
   req_t        m_e;
   int          rr;
   logic [15:0] rdy_pat  = 16'hB5EF;
   logic [15:0] ifid_pat = 16'hE7B3;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: wait bound expired", name, cyc);
   endtask

   // Memory: answers the oldest accepted request once its latency has elapsed.
   task automatic drive_mem();
      if (rst_n && inflight.size() != 0 && inflight[0].due <= cyc) begin
         imemRespValid = 1'b1;
         imemRespData  = mem_word(inflight[0].addr);
      end else if (stray) begin
         imemRespValid = 1'b1;
         imemRespData  = 32'hDEAD_0000 | cyc;
      end else begin
         imemRespValid = 1'b0;
         imemRespData  = 32'h0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      drive_mem();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic wait_inflight(input int n, input string name);
      int i = 0;
      while (inflight.size() != n && i < 20) begin
         step();
         i++;
      end
      if (inflight.size() != n) timeout(name);
   endtask

   task automatic drain();
      int i = 0;
      PCLocker = 1'b0;
      while (inflight.size() != 0 && i < 20) begin
         step();
         i++;
      end
      if (inflight.size() != 0) timeout("drain");
      step();
   endtask

   // Compare DUT against the reference every cycle, then advance the reference.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk1("rst_req_valid", imemReqValid, 1'b0);
         chk("rst_req_addr", imemReqAddr, RST_PC);
         chk1("rst_inst_valid", instValid, 1'b0);
         chk("rst_inst_data", instData, 32'h0);
         chk("rst_inst_pc", instPC, 32'h0);
         inflight.delete();
         expq.delete();
         m_pc = RST_PC;
      end else begin
         m_exp_valid = (expq.size() != 0);
         m_pop       = m_exp_valid && IF_IDLocker && !redirectValid;
         m_exp_req   = PCLocker && !redirectValid &&
                       ((int'(expq.size()) - int'(m_pop) + int'(inflight.size())) < QD);
         chk1("req_valid", imemReqValid, m_exp_req);
         if (m_exp_req) chk("req_addr", imemReqAddr, m_pc);
         chk1("inst_valid", instValid, m_exp_valid);
         if (m_exp_valid) begin
            chk("inst_pc", instPC, expq[0].pc);
            chk("inst_data", instData, expq[0].data);
         end
         m_resp = imemRespValid && (inflight.size() != 0);
         if (m_pop) void'(expq.pop_front());
         if (m_resp) begin
            m_e = inflight.pop_front();
            if (m_e.live && !redirectValid)
               expq.push_back('{pc: m_e.addr, data: mem_word(m_e.addr)});
         end
         if (redirectValid) begin
            expq.delete();
            foreach (inflight[i]) inflight[i].live = 1'b0;
            m_pc = {redirectPC[31:2], 2'b00};
         end else if (m_exp_req && imemReqReady) begin
            inflight.push_back('{addr: m_pc, due: cyc + lat, live: 1'b1});
            m_pc = m_pc + 32'd4;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset and streaming fetch, L = 1.
      PCLocker    = 1'b1;
      IF_IDLocker = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      cyc   = 1;
      #1;
      chk1("c1_req_valid", imemReqValid, 1'b1);
      chk("c1_req_addr", imemReqAddr, 32'h100);
      step(); #1;
      chk("c2_req_addr", imemReqAddr, 32'h104);
      chk1("c2_inst_valid", instValid, 1'b0);
      step(); #1;
      chk1("c3_inst_valid", instValid, 1'b1);
      chk("c3_inst_pc", instPC, 32'h100);
      chk("c3_inst_data", instData, mem_word(32'h100));
      chk("c3_req_addr", imemReqAddr, 32'h108);
      step(); #1;
      chk("c4_inst_pc", instPC, 32'h104);

      // Decode stall for cycles 11..14.
      run_to(11);
      IF_IDLocker = 1'b0;
      #1;
      chk1("stall_req_valid_11", imemReqValid, 1'b0);
      chk("stall_inst_pc_11", instPC, 32'h120);
      run_to(13); #1;
      chk1("stall_req_valid_13", imemReqValid, 1'b0);
      chk1("stall_inst_valid_13", instValid, 1'b1);
      chk("stall_inst_pc_13", instPC, 32'h120);
      run_to(15);
      IF_IDLocker = 1'b1;
      #1;
      chk("resume_inst_pc_15", instPC, 32'h120);
      chk1("resume_req_valid_15", imemReqValid, 1'b1);
      chk("resume_req_addr_15", imemReqAddr, 32'h128);
      run_to(16); #1;
      chk("resume_inst_pc_16", instPC, 32'h124);
      run_to(17); #1;
      chk("resume_inst_pc_17", instPC, 32'h128);

      // PC hold for cycles 20..22 with one request outstanding.
      run_to(20);
      PCLocker = 1'b0;
      #1;
      chk1("hold_req_valid_20", imemReqValid, 1'b0);
      chk("hold_inst_pc_20", instPC, 32'h134);
      run_to(21); #1;
      chk1("hold_inst_valid_21", instValid, 1'b1);
      chk("hold_inst_pc_21", instPC, 32'h138);
      run_to(22); #1;
      chk1("hold_inst_valid_22", instValid, 1'b0);
      chk1("hold_req_valid_22", imemReqValid, 1'b0);
      chk("hold_pc_22", imemReqAddr, 32'h13C);
      run_to(23);
      PCLocker = 1'b1;
      #1;
      chk1("hold_release_req_valid", imemReqValid, 1'b1);
      chk("hold_release_req_addr", imemReqAddr, 32'h13C);
      run_to(26);

      // Redirect with two requests in flight, L = 3.
      drain();
      lat      = 3;
      PCLocker = 1'b1;
      wait_inflight(2, "redir_fill");
      redirectValid = 1'b1;
      redirectPC    = 32'h0000_2002;
      rr            = cyc;
      #1;
      chk1("redir_no_req", imemReqValid, 1'b0);
      step();
      redirectValid = 1'b0;
      #1;
      chk1("redir_r1_req_valid", imemReqValid, 1'b0);
      run_to(rr + 2); #1;
      chk1("redir_r2_req_valid", imemReqValid, 1'b1);
      chk("redir_r2_req_addr", imemReqAddr, 32'h2000);
      run_to(rr + 5); #1;
      chk1("redir_r5_inst_valid", instValid, 1'b0);
      run_to(rr + 6); #1;
      chk1("redir_r6_inst_valid", instValid, 1'b1);
      chk("redir_r6_inst_pc", instPC, 32'h2000);
      chk("redir_r6_inst_data", instData, mem_word(32'h2000));

      // Redirect in the same cycle as a response, L = 1.
      drain();
      lat      = 1;
      PCLocker = 1'b1;
      begin
         int i = 0;
         while (!(inflight.size() == 1 && inflight[0].due <= cyc) && i < 20) begin
            step();
            i++;
         end
         if (!(inflight.size() == 1 && inflight[0].due <= cyc)) timeout("same_resp_setup");
      end
      redirectValid = 1'b1;
      redirectPC    = 32'h0000_3000;
      rr            = cyc;
      #1;
      chk1("same_resp_no_req", imemReqValid, 1'b0);
      step();
      redirectValid = 1'b0;
      #1;
      chk1("same_r1_req_valid", imemReqValid, 1'b1);
      chk("same_r1_req_addr", imemReqAddr, 32'h3000);
      chk1("same_r1_inst_valid", instValid, 1'b0);
      run_to(rr + 2); #1;
      chk1("same_r2_inst_valid", instValid, 1'b0);
      run_to(rr + 3); #1;
      chk1("same_r3_inst_valid", instValid, 1'b1);
      chk("same_r3_inst_pc", instPC, 32'h3000);
      run_to(rr + 4); #1;
      chk("same_r4_inst_pc", instPC, 32'h3004);

      // Reset with two requests in flight, then two stray responses.
      drain();
      lat      = 3;
      PCLocker = 1'b1;
      wait_inflight(2, "reset_fill");
      rst_n = 1'b0;
      #1;
      chk1("midrst_req_valid", imemReqValid, 1'b0);
      chk("midrst_req_addr", imemReqAddr, RST_PC);
      chk1("midrst_inst_valid", instValid, 1'b0);
      step();
      step();
      PCLocker = 1'b0;
      stray    = 1'b1;
      rst_n    = 1'b1;
      cyc      = 1;
      drive_mem();
      #1;
      chk1("stray1_req_valid", imemReqValid, 1'b0);
      step();
      stray = 1'b0;
      #1;
      chk1("stray2_inst_valid", instValid, 1'b0);
      step(); #1;
      chk1("stray_after_inst_valid", instValid, 1'b0);
      PCLocker = 1'b1;
      #1;
      chk1("restart_req_valid", imemReqValid, 1'b1);
      chk("restart_req_addr", imemReqAddr, RST_PC);
      run_to(6); #1;
      chk1("restart_c6_inst_valid", instValid, 1'b0);
      run_to(7); #1;
      chk1("restart_c7_inst_valid", instValid, 1'b1);
      chk("restart_c7_inst_pc", instPC, RST_PC);

      // Mixed backpressure, stalls and one redirect, L = 2.
      lat = 2;
      for (int i = 0; i < 32; i++) begin
         step();
         imemReqReady  = rdy_pat[i % 16];
         IF_IDLocker   = ifid_pat[i % 16];
         PCLocker      = ((i % 11) != 7);
         redirectValid = (i == 20);
         redirectPC    = 32'h0000_0403;
      end
      step();
      redirectValid = 1'b0;
      imemReqReady  = 1'b1;
      IF_IDLocker   = 1'b1;
      drain();
      run_to(cyc + 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
